// File: rtl/windowed_reg_file.sv
// Windowed general-purpose register file.
// Instruction register selects are offsets into a 4-register window based at wp.
// Registers update on the falling edge of clk. Reads are combinational.
module windowed_reg_file #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned PHYS_REGS = 8,
    parameter int unsigned WP_W      = 3,
    parameter int unsigned SEL_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WP_W-1:0]   wp,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic [SEL_W-1:0]  rs_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rfl_write,
    input  logic              rfh_write,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rs_data
);

    localparam int unsigned HALF_W = DATA_W / 2;

    logic [DATA_W-1:0] regs_q [PHYS_REGS];
    logic [DATA_W-1:0] regs_d [PHYS_REGS];
    logic [WP_W-1:0]   phys_d;
    logic [WP_W-1:0]   phys_s;

    // Physical index: window base plus zero-extended offset, carry dropped so the window wraps
    always_comb begin
        phys_d = wp + WP_W'(rd_sel);
        phys_s = wp + WP_W'(rs_sel);
    end

    // Next array contents: only the addressed register, only the enabled byte lanes
    always_comb begin
        for (int unsigned i = 0; i < PHYS_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (WP_W'(i) == phys_d) begin
                if (rfl_write) begin
                    regs_d[i][HALF_W-1:0] = wr_data[HALF_W-1:0];
                end
                if (rfh_write) begin
                    regs_d[i][DATA_W-1:HALF_W] = wr_data[DATA_W-1:HALF_W];
                end
            end
        end
    end

    // Register array: falling-edge update, asynchronous clear dominates any pending write
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < PHYS_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PHYS_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Operand reads straight from the array, no write bypass
    assign rd_data = regs_q[phys_d];
    assign rs_data = regs_q[phys_s];

endmodule
